// File: rtl/dh_shared_key.sv
// Diffie-Hellman shared key: key = r^x mod p, square-and-multiply over bit-serial modmul.
// Optional DH_EARLY_EXIT_EN: stop scanning once the remaining exponent is zero.
module dh_shared_key #(
  parameter int W   = 32,
  parameter int R_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R_W-1:0] r,
  input  logic [W-1:0]   p,
  input  logic [W-1:0]   x,
  input  logic           st,
  output logic [W-1:0]   key,
  output logic           done,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    IDLE,
    RED,
    MUL_R,
    SQR,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  r_q, p_q, e_q, res_q, base_q, acc_q;
  logic [CW-1:0] cnt_q, bit_q;
  logic          bad_q;

  logic [W-1:0]  op_a, op_b, e_sh, mm_res;
  logic [W+1:0]  p_ext, t0, t1, t2;
  logic          a_bit, mm_last, p_bad;
  logic          red_end, mul_end, sqr_end;

  assign e_sh    = e_q >> 1;
  assign mm_last = (cnt_q == LAST);
  assign p_bad   = (p_q < W'(2));
  assign busy    = (state != IDLE);

`ifdef DH_EARLY_EXIT_EN
  assign red_end = (e_q == '0);
  assign mul_end = (e_sh == '0);
  assign sqr_end = (e_sh == '0) || (bit_q == LAST);
`else
  assign red_end = 1'b0;
  assign mul_end = 1'b0;
  assign sqr_end = (bit_q == LAST);
`endif

  // Operand selection for the shared modmul engine, MSB-first over a.
  always_comb begin
    op_a = r_q;
    op_b = W'(1);
    unique case (state)
      MUL_R: begin
        op_a = res_q;
        op_b = base_q;
      end
      SQR: begin
        op_a = base_q;
        op_b = base_q;
      end
      default: ;
    endcase
    a_bit  = op_a[LAST - cnt_q];
    p_ext  = {2'b00, p_q};
    t0     = {1'b0, acc_q, 1'b0} + (a_bit ? {2'b00, op_b} : '0);
    t1     = (t0 >= p_ext) ? t0 - p_ext : t0;
    t2     = (t1 >= p_ext) ? t1 - p_ext : t1;
    mm_res = t2[W-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: exponent bits consumed with no dedicated scan cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (st) state_nx = RED;
      RED:
        if (cnt_q == '0 && p_bad) state_nx = FIN;
        else if (mm_last) begin
          if (red_end)     state_nx = FIN;
          else if (e_q[0]) state_nx = MUL_R;
          else             state_nx = SQR;
        end
      MUL_R:
        if (mm_last) state_nx = mul_end ? FIN : SQR;
      SQR:
        if (mm_last) begin
          if (sqr_end)      state_nx = FIN;
          else if (e_sh[0]) state_nx = MUL_R;
          else              state_nx = SQR;
        end
      FIN:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Operand latch, modmul accumulation and result/handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      p_q    <= '0;
      e_q    <= '0;
      res_q  <= '0;
      base_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
      bad_q  <= 1'b0;
      key    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE:
          if (st) begin
            r_q    <= {{(W-R_W){1'b0}}, r};
            p_q    <= p;
            e_q    <= x;
            res_q  <= W'(1);
            base_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            bit_q  <= '0;
            bad_q  <= 1'b0;
            err    <= 1'b0;
          end
        FIN: begin
          key  <= bad_q ? '0 : res_q;
          err  <= bad_q;
          done <= 1'b1;
        end
        default:
          if (state == RED && cnt_q == '0 && p_bad) begin
            bad_q <= 1'b1;
          end else if (mm_last) begin
            acc_q <= '0;
            cnt_q <= '0;
            unique case (state)
              MUL_R: res_q <= mm_res;
              SQR: begin
                base_q <= mm_res;
                e_q    <= e_sh;
                bit_q  <= bit_q + 1'b1;
              end
              default: base_q <= mm_res;
            endcase
          end else begin
            acc_q <= mm_res;
            cnt_q <= cnt_q + 1'b1;
          end
      endcase
    end
  end

endmodule

// File: tb/tb_dh_shared_key.sv
// Directed bench for dh_shared_key: results, latency, handshake, reset abort.
// Expected latency follows DH_EARLY_EXIT_EN when defined.
module tb_dh_shared_key;

  localparam int W   = 32;
  localparam int R_W = 4;
  localparam int TMO = 3000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R_W-1:0] r   = '0;
  logic [W-1:0]   p   = '0;
  logic [W-1:0]   x   = '0;
  logic           st  = 1'b0;
  logic [W-1:0]   key;
  logic           done, busy, err;

  int checks = 0;
  int errors = 0;

  dh_shared_key #(.W(W), .R_W(R_W)) dut (
    .clk(clk), .rst(rst), .r(r), .p(p), .x(x), .st(st),
    .key(key), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [W-1:0] xv);
    int pc, m;
    pc = $countones(xv);
`ifdef DH_EARLY_EXIT_EN
    if (xv == '0) return W + 1;
    m = 0;
    for (int i = 0; i < W; i++) if (xv[i]) m = i;
    return W * (1 + m + pc) + 1;
`else
    m = W;
    return W * (1 + m + pc) + 1;
`endif
  endfunction

  task automatic start(input logic [R_W-1:0] rv, input logic [W-1:0] pv,
                       input logic [W-1:0] xv);
    r  = rv;
    p  = pv;
    x  = xv;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < TMO) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic finish_chk(input string tag, input logic [W-1:0] ek,
                            input logic ee, input int el);
    int  n;
    bit  bok;
    wait_done(n, bok);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, n, el);
    chk({tag, "_key"}, key, ek);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_busy_run"}, bok, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic run(input string tag, input logic [R_W-1:0] rv,
                     input logic [W-1:0] pv, input logic [W-1:0] xv,
                     input logic [W-1:0] ek, input logic ee, input int el);
    start(rv, pv, xv);
    finish_chk(tag, ek, ee, el);
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_pulse1"}, done, 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key", key, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("r4p5x6", 4, 5, 6, 1, 0, lat(6));
    pulse_end("r4p5x6");

    run("r8p23x15", 8, 23, 15, 2, 0, lat(15));
    run("b2b_r9p5x3", 9, 5, 3, 4, 0, lat(3));
    pulse_end("b2b");

    run("x0", 7, 5, 0, 1, 0, lat(0));
    pulse_end("x0");

    run("p1", 3, 1, 9, 0, 1, 2);
    pulse_end("p1");
    run("p0", 3, 0, 9, 0, 1, 2);
    pulse_end("p0");
    run("err_clear", 4, 5, 6, 1, 0, lat(6));
    pulse_end("err_clear");

    r  = 8;
    p  = 23;
    x  = 15;
    st = 1'b1;
    @(posedge clk);
    #1;
    r = 3;
    p = 7;
    x = 3;
    finish_chk("st_held_1", 2, 0, lat(15));
    @(posedge clk);
    #1;
    st = 1'b0;
    chk("st_held_reaccept", busy, 1);
    finish_chk("st_held_2", 6, 0, lat(3));
    pulse_end("st_held");
    chk("st_held_idle", busy, 0);

    start(4, 5, 6);
    repeat (99) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_key", key, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (1300) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    run("restart", 4, 5, 6, 1, 0, lat(6));
    pulse_end("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
